// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the shared-divider scheduler.
//   div_state_e : scheduler FSM states (IDLE, DIV, RSP)
//   DW_DEF      : default operand width
//   DZ_QUOT     : quotient reported for a zero divisor at the default width
package div_pkg;

  localparam int unsigned DW_DEF = 16;

  localparam logic [DW_DEF-1:0] DZ_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    RSP  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: requester-side bundle of the shared-divider scheduler.
//   req_valid/req_ready : per-requester request handshake (ready one-hot or zero)
//   req_src1/req_src2   : packed dividends/divisors, requester i at [i*DW +: DW]
//   rsp_valid/rsp_ready : per-requester response handshake (valid one-hot)
//   calc_res            : {quotient, remainder}
//   rsp_dz              : divide-by-zero flag, qualified by rsp_valid
//   busy                : scheduler is not idle
// master = requester side, slave = scheduler side.
interface div_sched_if
  import div_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DW    = DW_DEF
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*DW-1:0] req_src1;
  logic [N_REQ*DW-1:0] req_src2;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [2*DW-1:0]     calc_res;
  logic                rsp_dz;
  logic                busy;

  modport master (
    output req_valid, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, calc_res, rsp_dz, busy
  );

  modport slave (
    input  req_valid, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, calc_res, rsp_dz, busy
  );

endinterface

// File: rtl/div_core.sv
// div_core: restoring divider, one quotient bit per cycle, MSB first.
//   clk, n_rst    : clock, synchronous active-low reset
//   i_start       : load operands and begin DW iterations
//   i_dividend    : dividend (sampled on i_start)
//   i_divisor     : divisor, must be nonzero (sampled on i_start)
//   o_done        : high during the final iteration cycle
//   o_quotient    : quotient, valid while o_done
//   o_remainder   : remainder, valid while o_done
module div_core
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_done,
  output logic [DW-1:0] o_quotient,
  output logic [DW-1:0] o_remainder
);

  localparam int unsigned CW = $clog2(DW) + 1;

  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_dvs;
  logic [DW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_run;

  logic [DW:0]   w_rem_sh;
  logic [DW:0]   w_diff;
  logic          w_ge;
  logic [DW-1:0] w_rem_nx;
  logic [DW-1:0] w_dvd_nx;

  // The working remainder is DW+1 bits wide (w_rem_sh); after the conditional
  // subtract it is always below the divisor, so only DW bits are stored.
  // Quotient bits fill the dividend register from the LSB as dividend bits
  // leave from the MSB, so after DW steps r_dvd holds the quotient.
  always_comb begin
    w_rem_sh = {r_rem, r_dvd[DW-1]};
    w_diff   = w_rem_sh - {1'b0, r_dvs};
    w_ge     = ~w_diff[DW];
    w_rem_nx = w_ge ? w_diff[DW-1:0] : w_rem_sh[DW-1:0];
    w_dvd_nx = {r_dvd[DW-2:0], w_ge};
  end

  // Combinational done lets the scheduler capture the final step's result
  // in the same edge that retires the last iteration.
  assign o_done      = r_run && (r_cnt == CW'(DW - 1));
  assign o_quotient  = w_dvd_nx;
  assign o_remainder = w_rem_nx;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_dvd <= i_dividend;
      r_dvs <= i_divisor;
      r_rem <= '0;
    end else if (r_run) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_dvd_nx;
      r_cnt <= r_cnt + CW'(1);
      if (o_done) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler in front of a single shared divider.
//   clk   : clock, rising edge
//   n_rst : synchronous active-low reset
//   bus   : div_sched_if.slave -- request/response handshakes, operands,
//           result {quotient, remainder}, divide-by-zero flag, busy
// Accepts one request per IDLE cycle, runs it through div_core (or answers a
// zero divisor immediately) and holds the result until the owner consumes it.
module div_sched
  import div_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  div_sched_if.slave  bus
);

  localparam int unsigned PW = $clog2(N_REQ);

  div_state_e      r_state;
  div_state_e      w_state_nx;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic [2*DW-1:0] r_res;
  logic            r_dz;

  logic [PW-1:0]   w_grant;
  logic            w_found;
  logic            w_hs;
  logic [PW-1:0]   w_ptr_nx;
  logic [DW-1:0]   w_src1;
  logic [DW-1:0]   w_src2;
  logic            w_dvs_zero;
  logic            w_start;
  logic            w_core_done;
  logic [DW-1:0]   w_quo;
  logic [DW-1:0]   w_rem;

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  always_comb begin : p_arb
    int unsigned idx;
    idx     = 0;
    w_grant = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!w_found && bus.req_valid[PW'(idx)]) begin
        w_found = 1'b1;
        w_grant = PW'(idx);
      end
    end
  end

  // Ready is only raised toward a valid requester, so ready implies handshake.
  assign w_hs       = n_rst && (r_state == IDLE) && w_found;
  assign w_ptr_nx   = (w_grant == PW'(N_REQ - 1)) ? '0 : w_grant + PW'(1);
  assign w_src1     = bus.req_src1[w_grant*DW +: DW];
  assign w_src2     = bus.req_src2[w_grant*DW +: DW];
  assign w_dvs_zero = (w_src2 == '0);
  assign w_start    = w_hs && !w_dvs_zero;

  div_core #(
    .DW (DW)
  ) u_core (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_start     (w_start),
    .i_dividend  (w_src1),
    .i_divisor   (w_src2),
    .o_done      (w_core_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_state_nx = w_dvs_zero ? RSP : DIV;
        end
      end
      DIV: begin
        if (w_core_done) begin
          w_state_nx = RSP;
        end
      end
      RSP: begin
        if (bus.rsp_ready[r_owner]) begin
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_res   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_hs) begin
        r_owner <= w_grant;
        r_ptr   <= w_ptr_nx;
        if (w_dvs_zero) begin
          r_res <= {{DW{1'b1}}, w_src1};
          r_dz  <= 1'b1;
        end
      end
      if ((r_state == DIV) && w_core_done) begin
        r_res <= {w_quo, w_rem};
        r_dz  <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      bus.req_ready[k] = w_hs && (w_grant == PW'(k));
      bus.rsp_valid[k] = (r_state == RSP) && (r_owner == PW'(k));
    end
  end

  assign bus.calc_res = r_res;
  assign bus.rsp_dz   = r_dz;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;

  localparam int N = 2;
  localparam int W = 16;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  div_sched_if #(.N_REQ(N), .DW(W)) bus ();

  div_sched #(.N_REQ(N), .DW(W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_WAIT, M_RSP} mph_e;
  bit              m_init = 0;
  mph_e            m_ph = M_IDLE;
  int              m_ptr, m_owner, m_left;
  logic [2*W-1:0]  m_pend, m_calc;
  logic            m_dz;
  bit              m_clean;
  logic [N-1:0]    m_acc;
  int              g_m;
  logic [W-1:0]    a_m, b_m;

  function automatic int first_valid(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    m_acc = '0;
    if (!n_rst) begin
      m_init = 1; m_ph = M_IDLE; m_ptr = 0; m_owner = 0;
      m_calc = '0; m_dz = 1'b0; m_clean = 1;
    end else if (m_init) begin
      case (m_ph)
        M_IDLE: begin
          g_m = first_valid(m_ptr, bus.req_valid);
          if (g_m >= 0) begin
            m_acc[g_m] = 1'b1;
            m_owner = g_m;
            m_ptr = (g_m + 1) % N;
            a_m = bus.req_src1[g_m*W +: W];
            b_m = bus.req_src2[g_m*W +: W];
            if (b_m == 0) begin
              m_calc = {{W{1'b1}}, a_m}; m_dz = 1'b1; m_ph = M_RSP; m_clean = 0;
            end else begin
              m_pend = {a_m / b_m, a_m % b_m}; m_left = W; m_ph = M_WAIT;
            end
          end
        end
        M_WAIT: begin
          m_left--;
          if (m_left == 0) begin
            m_calc = m_pend; m_dz = 1'b0; m_ph = M_RSP; m_clean = 0;
          end
        end
        M_RSP: if (bus.rsp_ready[m_owner]) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  logic [N-1:0] c_rdy, c_val;
  int c_g;
  always @(negedge clk) begin
    if (m_init) begin
      c_rdy = '0;
      c_val = '0;
      if (n_rst && m_ph == M_IDLE) begin
        c_g = first_valid(m_ptr, bus.req_valid);
        if (c_g >= 0) c_rdy[c_g] = 1'b1;
      end
      if (m_ph == M_RSP) c_val[m_owner] = 1'b1;
      chk("req_ready", bus.req_ready, c_rdy);
      chk("rsp_valid", bus.rsp_valid, c_val);
      chk("busy", bus.busy, m_ph != M_IDLE);
      if (m_ph == M_RSP || m_clean) begin
        chk("calc_res", bus.calc_res, m_calc);
        chk("rsp_dz", bus.rsp_dz, m_dz);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_src1[idx*W +: W] = a;
    bus.req_src2[idx*W +: W] = b;
    bus.req_valid[idx] = 1'b1;
  endtask

  task automatic wait_accept(input int idx);
    bit seen;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin seen = 1; break; end
    end
    chk("accept_seen", seen, 1);
    tick();
    bus.req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(input int idx, input logic [2*W-1:0] exp_res, input logic exp_dz,
                          input int exp_lat, input int hold);
    bit seen;
    int n, oth;
    logic [N-1:0] own;
    oth = (idx + 1) % N;
    own = '0; own[idx] = 1'b1;
    seen = 0; n = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.rsp_valid[idx]) begin seen = 1; n = k; break; end
    end
    chk("rsp_latency", 64'(n), 64'(exp_lat));
    if (seen) begin
      chk("rsp_value", bus.calc_res, exp_res);
      chk("rsp_dz_val", bus.rsp_dz, exp_dz);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      bus.rsp_ready[oth] = ~bus.rsp_ready[oth];
      @(negedge clk);
      chk("hold_res", bus.calc_res, exp_res);
      chk("hold_valid", bus.rsp_valid, own);
      chk("hold_ready", bus.req_ready, 0);
    end
    tick();
    bus.rsp_ready[oth] = 1'b0;
    bus.rsp_ready[idx] = 1'b1;
    tick();
    bus.rsp_ready[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("reach_idle", bus.busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int gseq[$];
    int exp_seq[4];
    logic [W-1:0] ra, rb;
    exp_seq = '{0, 1, 0, 1};
    bus.req_valid = '0;
    bus.req_src1  = '0;
    bus.req_src2  = '0;
    bus.rsp_ready = '0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_calc_res", bus.calc_res, 0);
    chk("rst_rsp_dz", bus.rsp_dz, 0);
    chk("rst_busy", bus.busy, 0);
    tick();
    n_rst = 1'b1;

    set_req(0, 16'd100, 16'd7);    wait_accept(0); wait_rsp(0, 32'h000E_0002, 1'b0, 17, 0);
    set_req(1, 16'hFFFF, 16'd1);   wait_accept(1); wait_rsp(1, 32'hFFFF_0000, 1'b0, 17, 0);
    set_req(1, 16'd3, 16'd7);      wait_accept(1); wait_rsp(1, 32'h0000_0003, 1'b0, 17, 0);
    set_req(0, 16'd5, 16'd0);      wait_accept(0); wait_rsp(0, 32'hFFFF_0005, 1'b1, 1, 0);

    // both requesters valid continuously from reset
    n_rst = 1'b0;
    set_req(0, 16'd20, 16'd3);
    set_req(1, 16'd9, 16'd2);
    bus.rsp_ready = '1;
    tick(); tick();
    n_rst = 1'b1;
    for (int k = 0; k < 200 && gseq.size() < 4; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) gseq.push_back(bus.req_ready[1] ? 1 : 0);
    end
    tick();
    bus.req_valid = '0;
    wait_idle(40);
    tick();
    bus.rsp_ready = '0;
    chk("grant_count", gseq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gseq.size()) chk("grant_order", gseq[k], exp_seq[k]);
    end

    // owner holds off the response; non-owner rsp_ready is toggled
    set_req(0, 16'd100, 16'd7); wait_accept(0);
    set_req(1, 16'd1, 16'd1);
    wait_rsp(0, 32'h000E_0002, 1'b0, 17, 5);
    wait_accept(1); wait_rsp(1, 32'h0001_0000, 1'b0, 17, 0);

    // reset in the middle of a division
    set_req(0, 16'd100, 16'd7); wait_accept(0);
    repeat (8) @(negedge clk);
    tick(); n_rst = 1'b0;
    tick(); n_rst = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", bus.req_ready, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_calc_res", bus.calc_res, 0);
    chk("abort_rsp_dz", bus.rsp_dz, 0);
    chk("abort_busy", bus.busy, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", bus.rsp_valid, 0);
    end
    tick();
    set_req(0, 16'd100, 16'd7);
    set_req(1, 16'd50, 16'd5);
    @(negedge clk);
    chk("restart_grant", bus.req_ready, 2'b01);
    tick();
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, 32'h000E_0002, 1'b0, 17, 0);
    wait_accept(1); wait_rsp(1, 32'h000A_0000, 1'b0, 17, 0);

    // randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          ra = W'($urandom);
          case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 7));
            3:       ra = W'($urandom_range(0, 40));
            default: rb = W'($urandom);
          endcase
          if ($urandom_range(0, 7) == 3) rb = W'($urandom_range(1, 300));
          set_req(i, ra, rb);
        end
      end
      bus.rsp_ready = N'($urandom);
    end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    wait_idle(40);
    tick();
    bus.rsp_ready = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
